// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter for a single-port unified memory
module mem_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 8,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ack,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          pc_stall,
  output logic          busy
);

  localparam int LW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [LW-1:0] LAT_LAST   = LW'(MEM_LAT - 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [LW-1:0] lat_cnt_q, lat_cnt_d;
  logic [SW-1:0] starve_cnt_q, starve_cnt_d;
  logic          grant_f_q, grant_f_d;   // 1 = current access belongs to fetch
  logic          we_q, we_d;             // latched direction of current access
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_re_q, mem_re_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          fetch_wins;

  // State and command registers; reset clears everything, even mid-access
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      starve_cnt_q <= '0;
      grant_f_q    <= 1'b0;
      we_q         <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_re_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      starve_cnt_q <= starve_cnt_d;
      grant_f_q    <= grant_f_d;
      we_q         <= we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_re_q     <= mem_re_d;
      mem_we_q     <= mem_we_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  // Arbitration, access sequencing and read-data capture
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    starve_cnt_d = starve_cnt_q;
    grant_f_d    = grant_f_q;
    we_d         = we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_re_d     = mem_re_q;
    mem_we_d     = mem_we_q;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    // Data has priority unless fetch has already lost STARVE_MAX times in a row
    fetch_wins   = if_req && (!d_req || (starve_cnt_q == STARVE_TOP));

    case (state_q)
      IDLE: begin
        if (if_req || d_req) begin
          state_d   = ACCESS;
          lat_cnt_d = '0;
          grant_f_d = fetch_wins;
          if (fetch_wins) begin
            mem_addr_d   = if_addr;
            we_d         = 1'b0;
            mem_re_d     = 1'b1;
            mem_we_d     = 1'b0;
            starve_cnt_d = '0;
          end else begin
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            we_d        = d_we;
            mem_re_d    = !d_we;
            mem_we_d    = d_we;
            if (if_req && (starve_cnt_q != STARVE_TOP)) begin
              starve_cnt_d = starve_cnt_q + SW'(1);
            end
          end
        end
      end

      ACCESS: begin
        if (lat_cnt_q == LAT_LAST) begin
          state_d  = RESP;
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          if (!we_q) begin
            if (grant_f_q) begin
              if_rdata_d = mem_rdata;
            end else begin
              d_rdata_d = mem_rdata;
            end
          end
        end else begin
          lat_cnt_d = lat_cnt_q + LW'(1);
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        mem_re_d = 1'b0;
        mem_we_d = 1'b0;
      end
    endcase
  end

  assign if_ack    = (state_q == RESP) && grant_f_q;
  assign d_ack     = (state_q == RESP) && !grant_f_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign pc_stall  = if_req && !if_ack;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (MEM_LAT 1 and 3 instances)
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     [2];
  logic       if_req    [2];
  logic [7:0] if_addr   [2];
  logic       if_ack    [2];
  logic [7:0] if_rdata  [2];
  logic       d_req     [2];
  logic       d_we      [2];
  logic [7:0] d_addr    [2];
  logic [7:0] d_wdata   [2];
  logic       d_ack     [2];
  logic [7:0] d_rdata   [2];
  logic [7:0] mem_addr  [2];
  logic       mem_re    [2];
  logic       mem_we    [2];
  logic [7:0] mem_wdata [2];
  logic [7:0] mem_rdata [2];
  logic       pc_stall  [2];
  logic       busy      [2];

  mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(1), .STARVE_MAX(4)) u_l1 (
    .clk(clk), .reset(rst_n[0]),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ack(if_ack[0]), .if_rdata(if_rdata[0]),
    .d_req(d_req[0]), .d_we(d_we[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
    .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_re(mem_re[0]), .mem_we(mem_we[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
    .pc_stall(pc_stall[0]), .busy(busy[0])
  );

  mem_arbiter #(.AW(8), .DW(8), .MEM_LAT(3), .STARVE_MAX(4)) u_l3 (
    .clk(clk), .reset(rst_n[1]),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ack(if_ack[1]), .if_rdata(if_rdata[1]),
    .d_req(d_req[1]), .d_we(d_we[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
    .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_re(mem_re[1]), .mem_we(mem_we[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
    .pc_stall(pc_stall[1]), .busy(busy[1])
  );

  // Memory model: unwritten locations read as addr ^ 0xA6 (so mem[0x05] = 0xA3)
  bit         wr_valid [2][256];
  logic [7:0] wr_data  [2][256];

  for (genvar g = 0; g < 2; g++) begin : g_mem
    assign mem_rdata[g] = !mem_re[g] ? 8'h00 :
                          (wr_valid[g][mem_addr[g]] ? wr_data[g][mem_addr[g]] : (mem_addr[g] ^ 8'hA6));
    always @(posedge clk) begin
      if (mem_we[g]) begin
        wr_valid[g][mem_addr[g]] <= 1'b1;
        wr_data[g][mem_addr[g]]  <= mem_wdata[g];
      end
    end
  end

  typedef struct packed {
    logic       fetch;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ack_cnt      [2] = '{0, 0};
  int if_ack_cnt   [2] = '{0, 0};
  int we_cycles    [2] = '{0, 0};
  logic [7:0] last_we_addr [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void push_exp(input int i, input logic f, input logic [7:0] d);
    exp_t e;
    e.fetch = f;
    e.data  = d;
    if (i == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endfunction

  function automatic int q_size(input int i);
    return (i == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic exp_t q_pop(input int i);
    if (i == 0) return exp_q0.pop_front();
    return exp_q1.pop_front();
  endfunction

  // Scoreboard monitor: every ack is matched against the oldest expectation
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (mem_re[i] || mem_we[i]) check("re_we_excl", {31'd0, mem_re[i] & mem_we[i]}, 32'd0);
      if (mem_we[i]) begin
        we_cycles[i]++;
        last_we_addr[i] = mem_addr[i];
      end
      if (if_ack[i] || d_ack[i]) begin
        exp_t e;
        ack_cnt[i]++;
        if (if_ack[i]) if_ack_cnt[i]++;
        check("ack_excl", {31'd0, if_ack[i] & d_ack[i]}, 32'd0);
        check("ack_pending", {31'd0, q_size(i) != 0}, 32'd1);
        if (q_size(i) != 0) begin
          e = q_pop(i);
          check("ack_kind", {31'd0, if_ack[i]}, {31'd0, e.fetch});
          check("ack_data", {24'd0, (if_ack[i] ? if_rdata[i] : d_rdata[i])}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts cycles from the request cycle (=1) to the ack cycle, then drops req
  task automatic wait_ack(input int i, input logic f, input int exp_n, input string tag);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = f ? if_ack[i] : d_ack[i];
      if (f) check({tag, "_stall"}, {31'd0, pc_stall[i]}, {31'd0, !seen});
    end
    check({tag, "_lat"}, n, exp_n);
    tick();
    if (f) if_req[i] = 1'b0;
    else   d_req[i]  = 1'b0;
  endtask

  initial begin
    int base_we;
    int base_if;
    int base_ack;
    int got;
    int n;

    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0; if_req[i] = 1'b0; if_addr[i] = 8'h00;
      d_req[i] = 1'b0; d_we[i] = 1'b0; d_addr[i] = 8'h00; d_wdata[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_if_ack", {31'd0, if_ack[i]}, 32'd0);
      check("rst_d_ack", {31'd0, d_ack[i]}, 32'd0);
      check("rst_mem_re", {31'd0, mem_re[i]}, 32'd0);
      check("rst_mem_we", {31'd0, mem_we[i]}, 32'd0);
      check("rst_mem_addr", {24'd0, mem_addr[i]}, 32'd0);
      check("rst_mem_wdata", {24'd0, mem_wdata[i]}, 32'd0);
      check("rst_if_rdata", {24'd0, if_rdata[i]}, 32'd0);
      check("rst_d_rdata", {24'd0, d_rdata[i]}, 32'd0);
      check("rst_busy", {31'd0, busy[i]}, 32'd0);
      rst_n[i] = 1'b1;
    end

    // Fetch of 0x05 on the MEM_LAT=1 instance
    tick();
    if_req[0] = 1'b1; if_addr[0] = 8'h05;
    push_exp(0, 1'b1, 8'hA3);
    wait_ack(0, 1'b1, 3, "t1");

    // Store 0x5C to 0x10 (d_rdata must keep its old 0x00), then load it back
    base_we = we_cycles[0];
    base_if = if_ack_cnt[0];
    tick();
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 8'h10; d_wdata[0] = 8'h5C;
    push_exp(0, 1'b0, 8'h00);
    wait_ack(0, 1'b0, 3, "t2_st");
    check("t2_we_cycles", we_cycles[0] - base_we, 1);
    check("t2_we_addr", {24'd0, last_we_addr[0]}, 32'h10);
    tick();
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h10; d_wdata[0] = 8'hFF;
    push_exp(0, 1'b0, 8'h5C);
    wait_ack(0, 1'b0, 3, "t2_ld");
    check("t2_no_if_ack", if_ack_cnt[0] - base_if, 0);

    // Both held high: grant order D,D,D,D,F,D,D,D,D,F
    tick();
    if_req[0] = 1'b1; if_addr[0] = 8'h05;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 8'h10;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) push_exp(0, 1'b0, 8'h5C);
      push_exp(0, 1'b1, 8'hA3);
    end
    got = 0;
    n = 0;
    while (got < 10 && n < 200) begin
      @(negedge clk);
      n++;
      if (if_ack[0] || d_ack[0]) got++;
      if (if_ack[0]) check("t3_starve_clr", {29'd0, u_l1.starve_cnt_q}, 32'd0);
    end
    check("t3_grants", got, 10);
    tick();
    if_req[0] = 1'b0; d_req[0] = 1'b0;

    // Simultaneous rise on the MEM_LAT=3 instance: data first, fetch one slot later
    tick();
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 8'h33;
    if_req[1] = 1'b1; if_addr[1] = 8'h44;
    push_exp(1, 1'b0, 8'h33 ^ 8'hA6);
    push_exp(1, 1'b1, 8'h44 ^ 8'hA6);
    wait_ack(1, 1'b0, 5, "t4_d");
    wait_ack(1, 1'b1, 5, "t4_f");

    // Reset during the second ACCESS cycle of a store
    tick();
    d_req[1] = 1'b1; d_we[1] = 1'b1; d_addr[1] = 8'h40; d_wdata[1] = 8'h77;
    repeat (3) @(negedge clk);
    check("t5_we_before", {31'd0, mem_we[1]}, 32'd1);
    base_ack = ack_cnt[1];
    rst_n[1] = 1'b0;
    #1;
    check("t5_we_async", {31'd0, mem_we[1]}, 32'd0);
    check("t5_busy_rst", {31'd0, busy[1]}, 32'd0);
    d_req[1] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n[1] = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_busy_after", {31'd0, busy[1]}, 32'd0);
    check("t5_no_ack", ack_cnt[1] - base_ack, 0);

    // Address change during ACCESS is ignored
    tick();
    d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 8'h20;
    push_exp(1, 1'b0, 8'h20 ^ 8'hA6);
    @(negedge clk);
    tick();
    d_addr[1] = 8'h30;
    repeat (3) begin
      @(negedge clk);
      check("t6_addr_access", {24'd0, mem_addr[1]}, 32'h20);
    end
    @(negedge clk);
    check("t6_ack", {31'd0, d_ack[1]}, 32'd1);
    check("t6_addr_resp", {24'd0, mem_addr[1]}, 32'h20);
    tick();
    d_req[1] = 1'b0;

    repeat (3) @(negedge clk);
    check("left_exp_l1", q_size(0), 0);
    check("left_exp_l3", q_size(1), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
